serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl.sv | 145 ++++++++++++++
 tb/tb_serial_add_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract sequencer around one shared
// 1-bit full-adder cell. One operand pair per start, LSB first, WIDTH
// steps, then a registered sum/c_out/ovf with a one-cycle done pulse.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; operands are captured on the start edge
// RUN   | one full-adder step per clock, WIDTH steps in total
// DONE  | result registers just loaded; done high for this one cycle

// Gate-level 1-bit full adder, the cell that is time-shared below.
module serial_add_fa (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  logic w_axb;
  logic w_ab;
  logic w_cx;

  assign w_axb = i_a ^ i_b;
  assign w_ab  = i_a & i_b;
  assign w_cx  = i_c & w_axb;
  assign o_s   = w_axb ^ i_c;
  assign o_c   = w_ab | w_cx;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PREV = CW'(WIDTH - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res_sh;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_msb_cin;
  logic [WIDTH-1:0] r_sum;
  logic             r_c_out;
  logic             r_ovf;

  logic w_fa_s;
  logic w_fa_c;

  serial_add_fa u_fa (
    .i_a (r_a_sh[0]),
    .i_b (r_b_sh[0]),
    .i_c (r_carry),
    .o_s (w_fa_s),
    .o_c (w_fa_c)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; start only matters in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == CNT_LAST) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, serial stepping and result load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_res_sh  <= '0;
      r_cnt     <= '0;
      r_carry   <= 1'b0;
      r_msb_cin <= 1'b0;
      r_sum     <= '0;
      r_c_out   <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : c_in;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_res_sh <= {w_fa_s, r_res_sh[WIDTH-1:1]};
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          r_carry  <= w_fa_c;
          r_cnt    <= r_cnt + CW'(1);
          // The carry produced by step WIDTH-2 is what feeds the MSB step.
          if (r_cnt == CNT_PREV) r_msb_cin <= w_fa_c;
          if (r_cnt == CNT_LAST) begin
            r_sum   <= {w_fa_s, r_res_sh[WIDTH-1:1]};
            r_c_out <= w_fa_c;
            r_ovf   <= r_msb_cin ^ w_fa_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (r_state == S_RUN);
  assign done  = (r_state == S_DONE);
  assign sum   = r_sum;
  assign c_out = r_c_out;
  assign ovf   = r_ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic         c_in;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  int n_checks = 0;
  int n_errors = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                        input logic isub, input logic icin,
                        input logic [7:0] es, input logic ec, input logic eo);
    int busy_cyc;
    bit seen;
    @(negedge clk);
    a = ia; b = ib; sub = isub; c_in = icin; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    busy_cyc = 0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (busy) busy_cyc++;
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_busy_cycles"}, 32'(busy_cyc), 32'd8);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_c_out"}, 32'(c_out), 32'(ec));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    int t1;
    int t2;
    logic [7:0] s_first;
    logic [7:0] s_mid;
    logic [7:0] s_second;

    rst = 1'b1; start = 1'b0; sub = 1'b0; c_in = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_c_out", 32'(c_out), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_no_start", 32'(busy), 32'd0);

    run_op("add_100_27",     8'd100, 8'd27,  1'b0, 1'b0, 8'd127, 1'b0, 1'b0);
    run_op("add_100_27_ci",  8'd100, 8'd27,  1'b0, 1'b1, 8'd128, 1'b0, 1'b1);
    run_op("wrap_255_1",     8'd255, 8'd1,   1'b0, 1'b0, 8'd0,   1'b1, 1'b0);
    run_op("ovf_127_1",      8'd127, 8'd1,   1'b0, 1'b0, 8'd128, 1'b0, 1'b1);
    run_op("ovf_64_64",      8'd64,  8'd64,  1'b0, 1'b0, 8'd128, 1'b0, 1'b1);
    run_op("ovf_128_128",    8'd128, 8'd128, 1'b0, 1'b0, 8'd0,   1'b1, 1'b1);
    run_op("sub_5_3",        8'd5,   8'd3,   1'b1, 1'b0, 8'd2,   1'b1, 1'b0);
    run_op("sub_5_3_ci_ign", 8'd5,   8'd3,   1'b1, 1'b1, 8'd2,   1'b1, 1'b0);
    run_op("sub_3_5",        8'd3,   8'd5,   1'b1, 1'b0, 8'd254, 1'b0, 1'b0);
    run_op("sub_128_1",      8'd128, 8'd1,   1'b1, 1'b0, 8'd127, 1'b1, 1'b1);

    // Start pulse and operand changes while busy must not disturb the op.
    @(negedge clk);
    a = 8'd10; b = 8'd20; sub = 1'b0; c_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'd200; b = 8'd200; sub = 1'b1; c_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    s_first = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        if (ndone == 0) s_first = sum;
        ndone++;
      end
    end
    chk("midop_done_count", 32'(ndone), 32'd1);
    chk("midop_sum", 32'(s_first), 32'd30);

    // Back-to-back with start held high.
    @(negedge clk);
    a = 8'd1; b = 8'd2; sub = 1'b0; c_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 a = 8'd50; b = 8'd60;
    t1 = -1; t2 = -1; s_first = '0; s_mid = '0; s_second = '0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 14) s_mid = sum;
      if (done) begin
        if (t1 < 0) begin
          t1 = k; s_first = sum;
        end else if (t2 < 0) begin
          t2 = k; s_second = sum; start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("b2b_first_done_at", 32'(t1), 32'd9);
    chk("b2b_spacing", 32'(t2 - t1), 32'd10);
    chk("b2b_first_sum", 32'(s_first), 32'd3);
    chk("b2b_hold_during_run", 32'(s_mid), 32'd3);
    chk("b2b_second_sum", 32'(s_second), 32'd110);

    // Abort in the 4th RUN cycle.
    @(negedge clk);
    a = 8'd7; b = 8'd9; sub = 1'b0; c_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_c_out", 32'(c_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    run_op("after_abort_10_20", 8'd10, 8'd20, 1'b0, 1'b0, 8'd30, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
